down_counter: RTL

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter.sv | 97 +++++++++
 1 files changed

// File: rtl/down_counter.sv
// Loadable down-counter with a three-state control FSM (IDLE / RUN / EXPIRED).
// A nonzero load starts a countdown; reaching terminal count either parks the
// counter in EXPIRED (one-shot) or reloads it and keeps running (periodic).
// Every output is a register, so nothing combinational reaches the ports.
module down_counter #(
    parameter int WIDTH       = 8,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] count_d;
    logic             done_d;

    // Next-state and next-output decode; load always wins over enable and ack.
    always_comb begin
        state_d  = state_q;
        count_d  = count;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != ZERO) ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (enable) begin
                        if (count > ONE) begin
                            count_d = count - ONE;
                        end else if (count == ONE) begin
                            // Terminal count: pulse done, then reload or park.
                            done_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                count_d = reload_q;
                            end else begin
                                count_d = ZERO;
                                state_d = EXPIRED;
                            end
                        end
                        // count == 0 cannot occur in RUN; nothing decrements from 0.
                    end
                end
                EXPIRED: begin
                    if (ack) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    // IDLE: hold everything, enable and ack are ignored.
                end
            endcase
        end
    end

    // State, count and registered flags; busy/expired mirror the next state so
    // they line up with the state register on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count    <= ZERO;
            reload_q <= ZERO;
            busy     <= 1'b0;
            done     <= 1'b0;
            expired  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            reload_q <= reload_d;
            busy     <= (state_d == RUN);
            done     <= done_d;
            expired  <= (state_d == EXPIRED);
        end
    end

endmodule
